// File: rtl/button_event_scheduler.sv
// Latches button presses, generates hold-to-repeat events off a slow tick, and
// serialises all events to one valid/ready consumer with round-robin fairness.
module button_event_scheduler #(
  parameter int unsigned NUM_BTN      = 5,
  parameter int unsigned HOLD_TICKS   = 50,
  parameter int unsigned REPEAT_TICKS = 10,
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned ID_W         = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic [NUM_BTN-1:0] btn_pulse,
  input  logic [NUM_BTN-1:0] btn_level,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic [ID_W-1:0]    evt_id,
  output logic               evt_repeat,
  output logic [NUM_BTN-1:0] overrun,
  input  logic               overrun_clr
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_TICKS - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_TICKS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_REPEAT
  } hold_st_e;

  hold_st_e           st_q  [NUM_BTN];
  logic [CNT_W-1:0]   cnt_q [NUM_BTN];
  logic [NUM_BTN-1:0] fire;

  logic [NUM_BTN-1:0] pending_q, pending_d;
  logic [NUM_BTN-1:0] flag_q, flag_d;
  logic [NUM_BTN-1:0] ovr_q, ovr_d;
  logic [NUM_BTN-1:0] set_evt, set_rep;
  logic [NUM_BTN-1:0] sel, grant;
  logic [ID_W-1:0]    last_q, win;
  logic               found, load;

  logic               evt_valid_q;
  logic [ID_W-1:0]    evt_id_q;
  logic               evt_repeat_q;

  // Repeat fires on the terminal tick of the current phase while still held.
  always_comb begin
    fire = '0;
    for (int unsigned i = 0; i < NUM_BTN; i++) begin
      if (tick && btn_level[i]) begin
        if ((st_q[i] == ST_HOLD && cnt_q[i] == HOLD_LAST) ||
            (st_q[i] == ST_REPEAT && cnt_q[i] == REP_LAST)) begin
          fire[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_BTN; i++) begin
        st_q[i]  <= ST_IDLE;
        cnt_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_BTN; i++) begin
        if (st_q[i] != ST_IDLE && !btn_level[i]) begin
          st_q[i]  <= ST_IDLE;
          cnt_q[i] <= '0;
        end else if (btn_pulse[i]) begin
          st_q[i]  <= ST_HOLD;
          cnt_q[i] <= '0;
        end else if (fire[i]) begin
          st_q[i]  <= ST_REPEAT;
          cnt_q[i] <= '0;
        end else if (tick && st_q[i] != ST_IDLE) begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign set_evt = btn_pulse | fire;
  assign set_rep = fire & ~btn_pulse;
  assign load    = !evt_valid_q || evt_ready;

  // Two passes give the rotated search order: above last first, then wrap.
  always_comb begin
    found = 1'b0;
    win   = '0;
    sel   = '0;
    for (int unsigned j = 0; j < NUM_BTN; j++) begin
      if (!found && pending_q[j] && (ID_W'(j) > last_q)) begin
        found  = 1'b1;
        win    = ID_W'(j);
        sel[j] = 1'b1;
      end
    end
    for (int unsigned j = 0; j < NUM_BTN; j++) begin
      if (!found && pending_q[j] && (ID_W'(j) <= last_q)) begin
        found  = 1'b1;
        win    = ID_W'(j);
        sel[j] = 1'b1;
      end
    end
  end

  assign grant = sel & {NUM_BTN{load}};

  // A set on a channel being granted refills it with the new event's flag;
  // a set on a still-pending channel merges, keeping the older flag.
  always_comb begin
    pending_d = set_evt | (pending_q & ~grant);
    ovr_d     = (set_evt & pending_q & ~grant) | (ovr_q & {NUM_BTN{!overrun_clr}});
    flag_d    = flag_q;
    for (int unsigned i = 0; i < NUM_BTN; i++) begin
      if (set_evt[i] && (grant[i] || !pending_q[i])) begin
        flag_d[i] = set_rep[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q    <= '0;
      flag_q       <= '0;
      ovr_q        <= '0;
      last_q       <= ID_W'(NUM_BTN - 1);
      evt_valid_q  <= 1'b0;
      evt_id_q     <= '0;
      evt_repeat_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      flag_q    <= flag_d;
      ovr_q     <= ovr_d;
      if (load) begin
        if (found) begin
          evt_valid_q  <= 1'b1;
          evt_id_q     <= win;
          evt_repeat_q <= |(flag_q & sel);
          last_q       <= win;
        end else begin
          evt_valid_q <= 1'b0;
        end
      end
    end
  end

  assign evt_valid  = evt_valid_q;
  assign evt_id     = evt_id_q;
  assign evt_repeat = evt_repeat_q;
  assign overrun    = ovr_q;

endmodule

// File: doc/button_event_scheduler.md
Name: button_event_scheduler

Overview:
- Sits between the per-button press detectors and the clock/alarm mode controller.
- Latches one-cycle press pulses from NUM_BTN buttons into per-button pending flags.
- Generates auto-repeat events for held buttons, timed off a slow tick.
- Serialises all events to a single consumer through a valid/ready interface with round-robin fairness.

Parameters:
- NUM_BTN, 5, number of button channels (2..8).
- HOLD_TICKS, 50, ticks a button must stay held after its press before the first repeat fires.
- REPEAT_TICKS, 10, ticks between successive repeats while the button stays held.
- CNT_W, 8, hold/repeat counter width; must satisfy HOLD_TICKS and REPEAT_TICKS <= 2^CNT_W.
- ID_W, 3, width of evt_id; must satisfy 2^ID_W >= NUM_BTN.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- tick  in  1  one-cycle timing strobe, e.g. 100 Hz.
- btn_pulse  in  NUM_BTN  one-cycle press pulses, already synchronised.
- btn_level  in  NUM_BTN  debounced, synchronised held level per button.
- evt_valid  out  1  event available.
- evt_ready  in  1  consumer accepts the event.
- evt_id  out  ID_W  index of the button for the presented event.
- evt_repeat  out  1  1 = auto-repeat event, 0 = genuine press.
- overrun  out  NUM_BTN  sticky flag: an event was lost on that channel.
- overrun_clr  in  1  synchronous clear of all overrun bits.

Behaviour:
- Reset: asynchronous, active-high. evt_valid=0, evt_id=0, evt_repeat=0, overrun=0. All pending and repeat flags cleared, all hold FSMs in IDLE with counters at 0. Round-robin pointer last=NUM_BTN-1, so button 0 has first priority. Asserting rst mid-operation discards any in-flight or presented event.
- Per-button hold FSM, states IDLE, HOLD, REPEAT:
  - IDLE -> HOLD on btn_pulse[i]; counter cleared.
  - HOLD/REPEAT -> IDLE whenever btn_level[i]=0. This has priority over tick and counter updates.
  - HOLD: on tick, counter increments. At the tick where counter==HOLD_TICKS-1: fire repeat, go to REPEAT, counter cleared.
  - REPEAT: on tick, counter increments. At the tick where counter==REPEAT_TICKS-1: fire repeat, counter cleared.
  - btn_pulse[i] while in HOLD or REPEAT: go to HOLD, counter cleared.
- Event set, per button i: set_i = btn_pulse[i] | repeat_fire_i.
  - pending[i] is set on set_i.
  - The stored repeat flag is 1 only for repeat_fire_i with no same-cycle pulse; a pulse wins a same-cycle collision.
- Grant:
  - The output stage loads when evt_valid=0 or (evt_valid & evt_ready).
  - Winner is the first pending[j] found searching j = last+1, last+2, ... modulo NUM_BTN.
  - On load: evt_valid<=1, evt_id<=j, evt_repeat<=flag[j], pending[j] cleared, last<=j.
  - If nothing is pending on a load opportunity: evt_valid<=0.
- Simultaneous set and grant on the same channel: pending stays 1 and the flag takes the new event's value (no loss, no overrun).
- Overrun: set_i while pending[i]=1 and i is not granted that cycle -> overrun[i]<=1; the event merges, and the flag keeps the older value.
  - overrun_clr clears all bits. A same-cycle new overrun wins over the clear.
- Handshake:
  - evt_id and evt_repeat are stable while evt_valid=1 and evt_ready=0.
  - evt_valid never drops without a handshake.
  - Throughput is one event per cycle.
- Latency: pulse sampled at edge k -> pending after edge k -> evt_valid after edge k+1 (2 cycles), given the output stage is free.
- Counters never wrap: they are cleared at their terminal value.

Test Plan:
- Reset then single press: btn_pulse=5'b00100 for 1 cycle, evt_ready=1 -> evt_valid=1 exactly 2 cycles later with evt_id=2, evt_repeat=0; evt_valid=0 the following cycle.
- Fairness: btn_pulse=5'b10011 for 1 cycle, evt_ready=1 -> events on consecutive cycles with evt_id 0, 1, 4; a repeat of the same stimulus is then served 0, 1, 4 (pointer at 4 wraps to 0).
- Backpressure: evt_ready=0 for 10 cycles with button 3 pending -> evt_id=3 stable throughout; a second pulse on 3 during the stall is held pending (no overrun); a third pulse sets overrun[3]=1.
- Auto-repeat: HOLD_TICKS=4, REPEAT_TICKS=2; pulse button 1 with btn_level[1]=1 held and a tick every 5 cycles -> first repeat event (evt_repeat=1, evt_id=1) after the 4th tick, then one after every 2nd tick; drop btn_level -> no further events.
- Collision: repeat fire and btn_pulse on button 0 in the same cycle -> one event with evt_repeat=0, FSM returns to HOLD. Separately, overrun_clr coincident with a new overrun -> overrun bit stays 1.
- Reset mid-stream: rst asserted while evt_valid=1 and 3 channels pending -> all outputs 0 immediately; after release, no events until a new pulse arrives.
